ethernet_udp_reply_serializer: RTL and testbench

// - Downstream of the UDP reply builder. Latches the finished reply (50-byte head = 8-byte preamble/SFD + 42-byte
//   Eth/IP/UDP header, left-aligned 63-byte payload buffer, payload size) on its ready pulse.
// - Emits the frame one byte per clock, zero-pads to the 60-byte Ethernet minimum, then appends CRC-32 FCS.
// - Enforces inter-frame gap before accepting the next reply. Output feeds the 8-bit serial MAC TX path.

---
 rtl/ethernet_udp_reply_serializer.sv | 110 +++++++++++
 tb/tb_ethernet_udp_reply_serializer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ethernet_udp_reply_serializer.sv
// ethernet_udp_reply_serializer: latches a finished UDP reply and streams it byte-wise
// with zero padding to the Ethernet minimum, CRC-32 FCS and inter-frame gap.
module ethernet_udp_reply_serializer #(
   parameter int PREAMBLE_BYTES = 8,
   parameter int HEADER_BYTES   = 42,
   parameter int PAYLOAD_MAX    = 63,
   parameter int MIN_FRAME      = 60,
   parameter int IFG_CYCLES     = 12
) (
   input  logic                                        i_clk,
   input  logic                                        i_reset,
   input  logic                                        i_start,
   input  logic [(PREAMBLE_BYTES+HEADER_BYTES)*8-1:0]  i_head,
   input  logic [PAYLOAD_MAX*8-1:0]                    i_payload,
   input  logic [15:0]                                 i_payload_size,
   output logic [7:0]                                  o_tx_data,
   output logic                                        o_tx_valid,
   output logic                                        o_tx_sof,
   output logic                                        o_tx_eof,
   output logic                                        o_busy,
   output logic                                        o_dropped
);
   localparam int HW = (PREAMBLE_BYTES + HEADER_BYTES) * 8;
   localparam int PW = PAYLOAD_MAX * 8;

   typedef enum logic [2:0] {IDLE, PRE, HDR, PAY, PAD, FCS, IFG} state_t;

   state_t        state, state_n;
   logic [6:0]    idx, size_r, size_c, pad;
   logic [HW-1:0] head_r;
   logic [PW-1:0] pay_r;
   logic [31:0]   crc;
   logic          accept;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
      return r;
   endfunction

   assign accept = state == IDLE && i_start;
   assign size_c = (i_payload_size > 16'(PAYLOAD_MAX)) ? 7'(PAYLOAD_MAX) : i_payload_size[6:0];
   // size_r is already clamped, so the pad count fits comfortably in 7 bits
   assign pad    = (7'(HEADER_BYTES) + size_r >= 7'(MIN_FRAME)) ? 7'd0
                 : 7'(MIN_FRAME - HEADER_BYTES) - size_r;

   always_comb begin
      state_n    = state;
      o_tx_data  = 8'd0;
      o_tx_valid = 1'b0;
      o_tx_sof   = 1'b0;
      o_tx_eof   = 1'b0;
      o_busy     = state != IDLE;
      case (state)
         IDLE: state_n = i_start ? PRE : IDLE;
         PRE: begin
            o_tx_data  = head_r[HW-1 -: 8];
            o_tx_valid = 1'b1;
            o_tx_sof   = idx == 7'd0;
            state_n    = idx == 7'(PREAMBLE_BYTES - 1) ? HDR : PRE;
         end
         HDR: begin
            o_tx_data  = head_r[HW-1 -: 8];
            o_tx_valid = 1'b1;
            state_n    = idx != 7'(HEADER_BYTES - 1) ? HDR : size_r != 7'd0 ? PAY : pad != 7'd0 ? PAD : FCS;
         end
         PAY: begin
            o_tx_data  = pay_r[PW-1 -: 8];
            o_tx_valid = 1'b1;
            state_n    = idx != size_r - 7'd1 ? PAY : pad != 7'd0 ? PAD : FCS;
         end
         PAD: begin
            o_tx_valid = 1'b1;
            state_n    = idx == pad - 7'd1 ? FCS : PAD;
         end
         FCS: begin
            o_tx_data  = ~crc[7:0];
            o_tx_valid = 1'b1;
            o_tx_eof   = idx == 7'd3;
            state_n    = idx == 7'd3 ? IFG : FCS;
         end
         IFG: state_n = idx == 7'(IFG_CYCLES - 1) ? IDLE : IFG;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= IDLE;
         idx       <= 7'd0;
         head_r    <= '0;
         pay_r     <= '0;
         size_r    <= 7'd0;
         crc       <= 32'hFFFFFFFF;
         o_dropped <= 1'b0;
      end else begin
         state     <= state_n;
         idx       <= (state_n != state || state == IDLE) ? 7'd0 : idx + 7'd1;
         o_dropped <= i_start && state != IDLE;
         head_r    <= accept ? i_head : (state == PRE || state == HDR) ? head_r << 8 : head_r;
         pay_r     <= accept ? i_payload : state == PAY ? pay_r << 8 : pay_r;
         size_r    <= accept ? size_c : size_r;
         // FCS is sent by shifting the finished CRC out, low byte first
         crc       <= accept ? 32'hFFFFFFFF
                    : (state == HDR || state == PAY || state == PAD) ? crc_byte(crc, o_tx_data)
                    : state == FCS ? crc >> 8 : crc;
      end
   end
endmodule

// File: tb/tb_ethernet_udp_reply_serializer.sv
// tb_ethernet_udp_reply_serializer: directed + randomized frames checked against a
// byte-queue reference model of the reply frame, FCS and gap timing.
module tb_ethernet_udp_reply_serializer;
   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [399:0] head;
   logic [503:0] pay;
   logic [15:0]  psize;
   logic [7:0]   tx_data;
   logic         tx_valid, sof, eof, busy, dropped;
   int           tests = 0;
   int           fails = 0;
   bit           pend = 0;
   logic [7:0]   exp[$];
   logic [7:0]   got[$];

   always #5 clk = ~clk;

   ethernet_udp_reply_serializer dut (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_head(head), .i_payload(pay),
      .i_payload_size(psize), .o_tx_data(tx_data), .o_tx_valid(tx_valid), .o_tx_sof(sof),
      .o_tx_eof(eof), .o_busy(busy), .o_dropped(dropped)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      tests++;
      assert (obs === want) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (pend) begin
         chk("dropped", 32'(dropped), 1);
         pend  = 0;
         start = 0;
      end else chk("no_drop", 32'(dropped), 0);
   endtask

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      c = c ^ {24'd0, b};
      for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
      return c;
   endfunction

   function automatic void build_exp();
      logic [31:0] c;
      int sz;
      exp.delete();
      sz = psize > 63 ? 63 : int'(psize);
      for (int k = 0; k < 50; k++) exp.push_back(head[399-8*k -: 8]);
      for (int k = 0; k < sz; k++) exp.push_back(pay[503-8*k -: 8]);
      while (exp.size() < 68) exp.push_back(8'h00);
      c = 32'hFFFFFFFF;
      for (int k = 8; k < exp.size(); k++) c = crc_upd(c, exp[k]);
      c = ~c;
      for (int k = 0; k < 4; k++) exp.push_back(c[8*k +: 8]);
   endfunction

   function automatic int len_of(input logic [15:0] s);
      int sz;
      sz = s > 63 ? 63 : int'(s);
      return 8 + (42 + sz > 60 ? 42 + sz : 60) + 4;
   endfunction

   task automatic set_preamble();
      for (int k = 0; k < 7; k++) head[399-8*k -: 8] = 8'h55;
      head[343:336] = 8'hD5;
   endtask

   task automatic randomize_frame(input logic [15:0] s);
      for (int k = 0; k < 50; k++) head[399-8*k -: 8] = 8'($urandom);
      for (int k = 0; k < 63; k++) pay[503-8*k -: 8] = 8'($urandom);
      set_preamble();
      psize = s;
   endtask

   task automatic run_frame(input int want_len, input int drop_byte, input int drop_ifg);
      int n;
      int idle;
      logic [31:0] r;
      build_exp();
      got.delete();
      chk("busy_before", 32'(busy), 0);
      start = 1;
      tick();
      start = 0;
      n = 0;
      while (tx_valid === 1'b1 && n < 200) begin
         got.push_back(tx_data);
         if (n < exp.size()) chk("byte", 32'(tx_data), 32'(exp[n]));
         chk("sof", 32'(sof), 32'(n == 0));
         chk("eof", 32'(eof), 32'(n == want_len - 1));
         chk("busy_tx", 32'(busy), 1);
         if (n == drop_byte) begin
            start = 1;
            head  = ~head;
            pay   = ~pay;
            psize = 16'd5;
            pend  = 1;
         end
         tick();
         n++;
      end
      chk("len", 32'(n), 32'(want_len));
      r = 32'hFFFFFFFF;
      for (int k = 8; k < got.size(); k++) r = crc_upd(r, got[k]);
      chk("residue", r, 32'hDEBB20E3);
      idle = 0;
      while (busy === 1'b1 && idle < 50) begin
         chk("ifg_valid", 32'(tx_valid), 0);
         chk("ifg_data", 32'(tx_data), 0);
         if (idle == drop_ifg) begin
            start = 1;
            pend  = 1;
         end
         tick();
         idle++;
      end
      chk("ifg_len", 32'(idle), 12);
   endtask

   initial begin
      rst = 1; start = 0; head = '0; pay = '0; psize = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(tx_valid), 0);
      chk("rst_data", 32'(tx_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_sof", 32'(sof), 0);
      chk("rst_drop", 32'(dropped), 0);
      rst = 0;
      tick();
      // size 0, header all 0x11
      for (int k = 8; k < 50; k++) head[399-8*k -: 8] = 8'h11;
      set_preamble();
      psize = 0;
      run_frame(72, -1, -1);
      // size 18, payload 0x00..0x11, exactly minimum frame
      randomize_frame(16'd18);
      for (int k = 0; k < 18; k++) pay[503-8*k -: 8] = 8'(k);
      run_frame(72, -1, -1);
      // maximum payload, all 0xA5
      randomize_frame(16'd63);
      pay = {63{8'hA5}};
      run_frame(117, -1, -1);
      // drops mid-frame and inside the gap (including its last cycle)
      randomize_frame(16'd20);
      run_frame(74, 10, 3);
      randomize_frame(16'd2);
      run_frame(72, 60, 11);
      // random sizes, random content
      for (int t = 0; t < 6; t++) begin
         randomize_frame(16'($urandom_range(0, 63)));
         run_frame(len_of(psize), t == 2 ? 40 : -1, t == 4 ? 0 : -1);
      end
      // reset at byte 30 aborts the frame
      randomize_frame(16'd30);
      start = 1;
      tick();
      start = 0;
      for (int k = 0; k < 30; k++) tick();
      rst = 1;
      #1;
      chk("abort_valid", 32'(tx_valid), 0);
      chk("abort_data", 32'(tx_data), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_eof", 32'(eof), 0);
      @(posedge clk);
      #1;
      rst = 0;
      tick();
      chk("post_rst_valid", 32'(tx_valid), 0);
      run_frame(84, -1, -1);
      // oversize clamps to 63, then a start on the first idle cycle
      randomize_frame(16'd100);
      run_frame(117, -1, -1);
      randomize_frame(16'd7);
      run_frame(72, -1, -1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
